// File: rtl/mem_arbiter.sv
// mem_arbiter: sequences the single unified instruction/data memory between the
// core control FSM and the program loader / debug port.
//
// One request is accepted per IDLE visit. It is issued for one cycle, and a read
// then waits WAIT_CYCLES cycles. DONE pulses the owner's ready for one cycle.
// IDLE is always revisited between transactions.
//
// Ports:
//   clk, reset                      clock (rising edge), async active-low reset
//   core_req/we/addr/wdata          core request, held until core_ready
//   core_rdata, core_ready          registered read data, one-cycle completion pulse
//   core_stall                      core_req & ~core_ready
//   ldr_req/we/addr/wdata           loader request, same semantics as the core port
//   ldr_rdata, ldr_ready            loader read data and completion pulse
//   ldr_lock                        while high the core is never granted
//   mem_en, mem_we                  memory enable / write strobe
//   mem_addr, mem_wdata             latched memory address / write data
//   mem_rdata                       memory read data
//   owner                           0 = core, 1 = loader (valid while busy)
//   busy                            high in ISSUE, WAIT and DONE
module mem_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_ready,
    output logic              core_stall,

    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ldr_ready,
    input  logic              ldr_lock,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              owner,
    output logic              busy
);

    localparam bit         HasWait  = (WAIT_CYCLES > 0);
    localparam logic [2:0] WaitLast = HasWait ? 3'(WAIT_CYCLES - 1) : 3'd0;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              owner_q, owner_d;
    logic              last_owner_q, last_owner_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
    logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;

    logic core_elig, ldr_elig, grant, grant_ldr, capture;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1; // core wins the first tie
            cnt_q        <= 3'd0;
            core_rdata_q <= '0;
            ldr_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            core_rdata_q <= core_rdata_d;
            ldr_rdata_q  <= ldr_rdata_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        core_rdata_d = core_rdata_q;
        ldr_rdata_d  = ldr_rdata_q;
        capture      = 1'b0;

        core_elig = core_req & ~ldr_lock;
        ldr_elig  = ldr_req;
        grant     = core_elig | ldr_elig;
        // On a tie, the requester that did not own the last transaction wins
        grant_ldr = (core_elig & ldr_elig) ? ~last_owner_q : ldr_elig;

        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    owner_d = grant_ldr;
                    we_d    = grant_ldr ? ldr_we    : core_we;
                    addr_d  = grant_ldr ? ldr_addr  : core_addr;
                    wdata_d = grant_ldr ? ldr_wdata : core_wdata;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d = 3'd0;
                if (we_q) begin
                    state_d = StDone;
                end else if (HasWait) begin
                    state_d = StWait;
                end else begin
                    // Combinational memory: data is valid during ISSUE
                    capture = 1'b1;
                    state_d = StDone;
                end
            end
            StWait: begin
                if (cnt_q == WaitLast) begin
                    capture = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StDone: begin
                last_owner_d = owner_q;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (capture) begin
            if (owner_q) begin
                ldr_rdata_d = mem_rdata;
            end else begin
                core_rdata_d = mem_rdata;
            end
        end
    end

    // Outputs
    always_comb begin
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        core_ready = 1'b0;
        ldr_ready  = 1'b0;
        busy       = (state_q != StIdle);

        unique case (state_q)
            StIssue: begin
                mem_en = 1'b1;
                mem_we = we_q;
            end
            StWait: begin
                mem_en = 1'b1;
            end
            StDone: begin
                core_ready = ~owner_q;
                ldr_ready  = owner_q;
            end
            default: ;
        endcase

        core_stall = core_req & ~core_ready;
    end

    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign owner      = owner_q;
    assign core_rdata = core_rdata_q;
    assign ldr_rdata  = ldr_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed stimulus with a scoreboard. Stimulus pushes
// the expected completion (port, read data, cycle) into a queue; a monitor pops
// and compares whenever a ready pulse appears. A second instance covers
// WAIT_CYCLES = 0.
module tb_mem_arbiter;

    typedef struct {
        bit          port;   // 0 = core, 1 = loader
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp0_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int c0;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    // WAIT_CYCLES = 1 instance
    logic        core_req = 0, core_we = 0, ldr_req = 0, ldr_we = 0, ldr_lock = 0;
    logic [31:0] core_addr = 0, core_wdata = 0, ldr_addr = 0, ldr_wdata = 0, mem_rdata = 0;
    logic [31:0] core_rdata, ldr_rdata, mem_addr, mem_wdata;
    logic        core_ready, core_stall, ldr_ready, mem_en, mem_we, owner, busy;

    // WAIT_CYCLES = 0 instance
    logic        core0_req = 0, core0_we = 0, ldr0_req = 0, ldr0_we = 0, ldr0_lock = 0;
    logic [31:0] core0_addr = 0, core0_wdata = 0, ldr0_addr = 0, ldr0_wdata = 0;
    logic [31:0] mem0_rdata = 0;
    logic [31:0] core0_rdata, ldr0_rdata, mem0_addr, mem0_wdata;
    logic        core0_ready, core0_stall, ldr0_ready, mem0_en, mem0_we, owner0, busy0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .core_ready(core_ready),
        .core_stall(core_stall),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_rdata(ldr_rdata), .ldr_ready(ldr_ready), .ldr_lock(ldr_lock),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset),
        .core_req(core0_req), .core_we(core0_we), .core_addr(core0_addr),
        .core_wdata(core0_wdata), .core_rdata(core0_rdata), .core_ready(core0_ready),
        .core_stall(core0_stall),
        .ldr_req(ldr0_req), .ldr_we(ldr0_we), .ldr_addr(ldr0_addr), .ldr_wdata(ldr0_wdata),
        .ldr_rdata(ldr0_rdata), .ldr_ready(ldr0_ready), .ldr_lock(ldr0_lock),
        .mem_en(mem0_en), .mem_we(mem0_we), .mem_addr(mem0_addr), .mem_wdata(mem0_wdata),
        .mem_rdata(mem0_rdata), .owner(owner0), .busy(busy0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input bit port, input logic [31:0] rdata, input int at);
        exp_t e;
        e.port  = port;
        e.rdata = rdata;
        e.cyc   = at;
        exp_q.push_back(e);
    endtask

    task automatic negs(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard monitor, WAIT_CYCLES = 1 instance
    always @(negedge clk) begin
        exp_t e;
        if (core_ready || ldr_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ready: core_ready=%b ldr_ready=%b, none expected (cycle %0d)",
                         core_ready, ldr_ready, cyc);
            end else begin
                e = exp_q.pop_front();
                check("ready_port", 32'({ldr_ready, core_ready}), e.port ? 32'd2 : 32'd1);
                check("rdata", e.port ? ldr_rdata : core_rdata, e.rdata);
                check("ready_cycle", cyc, e.cyc);
            end
        end
    end

    // Scoreboard monitor, WAIT_CYCLES = 0 instance
    always @(negedge clk) begin
        exp_t e;
        if (core0_ready || ldr0_ready) begin
            if (exp0_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL w0_unexpected_ready: core_ready=%b ldr_ready=%b (cycle %0d)",
                         core0_ready, ldr0_ready, cyc);
            end else begin
                e = exp0_q.pop_front();
                check("w0_ready_port", 32'({ldr0_ready, core0_ready}), e.port ? 32'd2 : 32'd1);
                check("w0_rdata", e.port ? ldr0_rdata : core0_rdata, e.rdata);
                check("w0_ready_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e0;

        // Reset state
        negs(2);
        check("rst_mem_en", 32'(mem_en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_owner", 32'(owner), 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_core_rdata", core_rdata, 0);
        check("rst_ready", 32'({core_ready, ldr_ready}), 0);
        check("rst_w0_busy", 32'(busy0), 0);
        reset = 1'b1;

        // Core read, WAIT_CYCLES = 1
        @(posedge clk); #1;
        c0 = cyc;
        core_req = 1; core_we = 0; core_addr = 32'h10; mem_rdata = 32'hDEADBEEF;
        push(0, 32'hDEADBEEF, c0 + 3);
        negs(1);
        check("rd_stall_c0", 32'(core_stall), 1);
        check("rd_mem_en_c0", 32'(mem_en), 0);
        negs(1);
        check("rd_mem_en_c1", 32'(mem_en), 1);
        check("rd_mem_we_c1", 32'(mem_we), 0);
        check("rd_mem_addr_c1", mem_addr, 32'h10);
        check("rd_stall_c1", 32'(core_stall), 1);
        negs(1);
        check("rd_mem_en_c2", 32'(mem_en), 1);
        check("rd_stall_c2", 32'(core_stall), 1);
        negs(1);
        check("rd_mem_en_c3", 32'(mem_en), 0);
        check("rd_stall_c3", 32'(core_stall), 0);
        core_req = 0;
        negs(1);
        check("rd_busy_after", 32'(busy), 0);
        check("rd_addr_retained", mem_addr, 32'h10);

        // Loader write
        @(posedge clk); #1;
        c0 = cyc;
        ldr_req = 1; ldr_we = 1; ldr_addr = 32'h20; ldr_wdata = 32'h12345678;
        push(1, 32'h0, c0 + 2);
        negs(2);
        check("wr_mem_en_c1", 32'(mem_en), 1);
        check("wr_mem_we_c1", 32'(mem_we), 1);
        check("wr_mem_addr_c1", mem_addr, 32'h20);
        check("wr_mem_wdata_c1", mem_wdata, 32'h12345678);
        check("wr_owner_c1", 32'(owner), 1);
        negs(1);
        check("wr_mem_en_c2", 32'(mem_en), 0);
        check("wr_mem_we_c2", 32'(mem_we), 0);
        check("wr_wdata_c2", mem_wdata, 32'h12345678);
        check("wr_core_rdata_kept", core_rdata, 32'hDEADBEEF);
        ldr_req = 0; ldr_we = 0;

        // Both requesting after reset: core, loader, core, loader
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        c0 = cyc;
        core_req = 1; core_we = 0; core_addr = 32'h30;
        ldr_req = 1; ldr_we = 0; ldr_addr = 32'h40;
        mem_rdata = 32'h5A5A0001;
        push(0, 32'h5A5A0001, c0 + 3);
        push(1, 32'h5A5A0001, c0 + 7);
        push(0, 32'h5A5A0001, c0 + 11);
        push(1, 32'h5A5A0001, c0 + 15);
        negs(6);
        check("rr_owner_c5", 32'(owner), 1);
        check("rr_addr_c5", mem_addr, 32'h40);
        check("rr_core_stall_c5", 32'(core_stall), 1);
        negs(10);
        core_req = 0; ldr_req = 0;

        // ldr_lock: three loader writes, no core grant, then the core
        @(posedge clk); #1;
        c0 = cyc;
        ldr_lock = 1;
        core_req = 1; core_we = 0; core_addr = 32'h50;
        ldr_req = 1; ldr_we = 1; ldr_addr = 32'h60; ldr_wdata = 32'hA0A0A0A0;
        mem_rdata = 32'h77770002;
        push(1, 32'h5A5A0001, c0 + 2);
        push(1, 32'h5A5A0001, c0 + 5);
        push(1, 32'h5A5A0001, c0 + 8);
        push(0, 32'h77770002, c0 + 12);
        negs(5);
        check("lk_owner_c4", 32'(owner), 1);
        check("lk_mem_we_c4", 32'(mem_we), 1);
        check("lk_core_stall_c4", 32'(core_stall), 1);
        negs(4);
        ldr_lock = 0; ldr_req = 0; ldr_we = 0;
        negs(2);
        check("lk_core_owner_c10", 32'(owner), 0);
        check("lk_core_addr_c10", mem_addr, 32'h50);
        negs(2);
        core_req = 0;

        // Lock raised during a core WAIT
        @(posedge clk); #1;
        c0 = cyc;
        core_req = 1; core_we = 0; core_addr = 32'h70; mem_rdata = 32'h33330003;
        push(0, 32'h33330003, c0 + 3);
        negs(3);
        ldr_lock = 1;
        negs(4);
        check("lw_not_granted_busy", 32'(busy), 0);
        check("lw_stall_locked", 32'(core_stall), 1);
        ldr_lock = 0; mem_rdata = 32'h44440004;
        push(0, 32'h44440004, c0 + 9);
        negs(3);
        core_req = 0;

        // Reset during the WAIT of a read
        @(posedge clk); #1;
        c0 = cyc;
        core_req = 1; core_we = 0; core_addr = 32'h80; mem_rdata = 32'h99990005;
        negs(3);
        reset = 1'b0;
        #1;
        check("ar_mem_en", 32'(mem_en), 0);
        check("ar_busy", 32'(busy), 0);
        check("ar_ready", 32'({core_ready, ldr_ready}), 0);
        check("ar_core_rdata", core_rdata, 0);
        check("ar_ldr_rdata", ldr_rdata, 0);
        check("ar_mem_addr", mem_addr, 0);
        @(negedge clk);
        reset = 1'b1;
        push(0, 32'h99990005, cyc + 3);
        negs(3);
        core_req = 0;

        // WAIT_CYCLES = 0 instance: combinational read
        @(posedge clk); #1;
        c0 = cyc;
        core0_req = 1; core0_we = 0; core0_addr = 32'h4; mem0_rdata = 32'hCAFE0001;
        e0.port = 0; e0.rdata = 32'hCAFE0001; e0.cyc = c0 + 2;
        exp0_q.push_back(e0);
        negs(2);
        check("w0_mem_en_c1", 32'(mem0_en), 1);
        check("w0_mem_addr_c1", mem0_addr, 32'h4);
        negs(1);
        check("w0_mem_en_c2", 32'(mem0_en), 0);
        core0_req = 0;

        negs(4);
        check("exp_q_drained", exp_q.size(), 0);
        check("exp0_q_drained", exp0_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequences and arbitrates the single unified instruction/data memory of the multicycle RISC-V core between two requesters: the core's control FSM (fetch, load, store) and the program loader/debug port. It latches one request at a time, drives the memory port for a fixed number of wait cycles, returns read data with a one-cycle ready pulse, and stalls the loser. It sits between the core's address mux / loader and the memory macro.

## Interface

- ADDR_W, 32, address width
- DATA_W, 32, data width
- WAIT_CYCLES, 1, memory read latency after the issue cycle, 0..7. 0 means combinational read; 1 means synchronous BRAM.

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- core_req  in  1  core access request, held until core_ready
- core_we  in  1  1 = write, 0 = read
- core_addr  in  ADDR_W  core address
- core_wdata  in  DATA_W  core write data
- core_rdata  out  DATA_W  registered read data for the core
- core_ready  out  1  one-cycle completion pulse
- core_stall  out  1  core_req & ~core_ready, combinational
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_rdata, ldr_ready  loader port, same meaning and widths as the core port
- ldr_lock  in  1  while high, the core is never granted
- mem_en  out  1  memory enable
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address, latched
- mem_wdata  out  DATA_W  memory write data, latched
- mem_rdata  in  DATA_W  memory read data
- owner  out  1  0 = core, 1 = loader; valid while busy
- busy  out  1  high in ISSUE, WAIT and DONE

## Operation

- **States:** IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - Sample the requests. Eligible core = core_req & ~ldr_lock; eligible loader = ldr_req.
  - If one is eligible, grant it. If both are eligible, grant the one that is not last_owner (round-robin).
  - On grant, latch addr, we and wdata into the mem_* registers, set owner, and go to ISSUE.
  - With no eligible request, stay in IDLE.
- **ISSUE** (one cycle)
  - mem_en=1, mem_we=latched we.
  - A write goes to DONE.
  - A read goes to WAIT if WAIT_CYCLES>0. If WAIT_CYCLES=0, it captures mem_rdata at the end of ISSUE and goes to DONE.
- **WAIT**
  - mem_en=1, mem_we=0, address held.
  - A 3-bit counter runs WAIT_CYCLES cycles.
  - mem_rdata is captured into the owner's rdata register at the edge leaving the last WAIT cycle, then go to DONE.
- **DONE** (one cycle)
  - mem_en=0. The owner's ready pulse is 1.
  - last_owner is updated to owner. Go to IDLE.
- **Read data registers:** written only on that requester's reads and held otherwise. Writes leave rdata unchanged.
- **Requests sampled only in IDLE.**
  - Deasserting req mid-transaction does not abort it; ready still pulses.
  - A req still high in the IDLE cycle after DONE starts a new transaction.
- **ldr_lock:**
  - Rising mid-core-transaction does not abort it; the core completes normally, then is not granted again until ldr_lock is low in an IDLE cycle.
  - Lock does not affect loader eligibility.
- **Loser:** a requester not granted keeps its req high and sees no ready.

## Timing

- **Reset** (asynchronous, immediate) forces:
  - state = IDLE.
  - mem_en, mem_we, ready outputs = 0.
  - mem_addr, mem_wdata, core_rdata, ldr_rdata = 0.
  - owner=0, busy=0.
  - last_owner = loader, so the core wins the first tie.
- **Reset during ISSUE of a write:** mem_we drops immediately; whether the memory write took effect is unspecified. No ready pulse is issued for an aborted transaction.
- **Latency from req first seen in IDLE (cycle 0):**
  - Write: ISSUE at c1, ready at c2.
  - Read: ISSUE at c1, WAIT at c2..c(1+WAIT_CYCLES), ready at c(2+WAIT_CYCLES).
- **Throughput:** minimum transaction spacing is 3 cycles for writes and 3+WAIT_CYCLES cycles for reads, because IDLE is always visited between transactions.
- **core_stall:** high from the cycle core_req rises through the cycle before core_ready, including cycles lost to arbitration or lock.
- **mem_addr/mem_wdata:** stable from ISSUE through DONE. They retain their last value in IDLE.

## Test plan

- **Core read, WAIT_CYCLES=1:** core_addr=0x10, mem_rdata=0xDEADBEEF at c2 -> mem_en=1 at c1–c2, core_ready=1 at c3, core_rdata=0xDEADBEEF, core_stall=1 at c0–c2.
- **Loader write:** ldr_addr=0x20, ldr_wdata=0x12345678 -> mem_en=mem_we=1 only at c1, mem_addr=0x20, ldr_ready at c2, ldr_rdata unchanged.
- **Both requesting continuously after reset:** grant order is core, loader, core, loader. Only the owner's ready pulses; the other's stall persists.
- **ldr_lock=1 with core_req and ldr_req held:** three loader transactions complete with no core grant.
  - Drop ldr_lock -> core is granted in the next IDLE.
  - Lock raised during a core WAIT -> the core still completes.
- **Reset pulse during WAIT of a read:** mem_en, busy and ready go to 0 asynchronously, rdata = 0. After release the block is in IDLE and a held core_req restarts the transaction, ready at +3.
- **WAIT_CYCLES=0 instance:** core read of 0x4 with combinational mem_rdata=0xCAFE0001 -> core_ready at c2, core_rdata=0xCAFE0001.
